// File: rtl/ps2_pkg.sv
// Shared types and protocol constants for the PS/2 keyboard controller.
package ps2_pkg;

   typedef enum logic [3:0] {
      StRstTx,
      StRstWait,
      StRstAck,
      StRstBat,
      StIdle,
      StCmdTx,
      StCmdWait,
      StCmdAck,
      StFail,
      StRsdTx,
      StRsdWait
   } state_t;

   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_RESEND   = 8'hFE;
   localparam logic [7:0] RSP_ACK      = 8'hFA;
   localparam logic [7:0] RSP_RESEND   = 8'hFE;
   localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
   localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

   // Clock cycles spanned by a timeout given in milliseconds.
   function automatic int unsigned ms_to_ticks(input int unsigned clk_hz, input int unsigned ms);
      return (clk_hz / 1000) * ms;
   endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous scancode FIFO. Pop on empty is ignored; push on full is dropped unless a pop
// happens in the same cycle, in which case the pop frees the slot first. Depth must be a
// power of two (>= 2) so the pointers wrap naturally.
module ps2_rx_fifo #(
   parameter int unsigned Depth = 8,
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [Width-1:0] push_data_i,
   input  logic             pop_i,
   output logic [Width-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AddrW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AddrW:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AddrW + 1)'(Depth));
   assign head_o  = mem_q[rd_ptr_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AddrW + 1)'(1);
         2'b01:   count_d = count_q - (AddrW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: sequences a byte-level PS2Host through the power-on reset
// handshake, sends CPU command bytes with ACK/resend/timeout retries, and buffers
// scancodes in a FIFO.
// Optional feature macro PS2_KBD_RESEND_EN: a parity-error byte seen in IDLE or while
// waiting for an ACK makes the controller send a single 0xFE resend request.
module ps2_kbd_ctrl
   import ps2_pkg::*;
#(
   parameter int unsigned clkf           = 50000000,
   parameter int unsigned ack_timeout_ms = 20,
   parameter int unsigned bat_timeout_ms = 1000,
   parameter int unsigned max_retries    = 3,
   parameter int unsigned fifo_depth     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] host_rx,
   input  logic       host_rx_valid,
   input  logic       host_error,
   output logic       host_start_tx,
   output logic [7:0] host_tx,
   input  logic       host_tx_busy,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       empty,
   output logic       overflow,
   output logic       cmd_done,
   output logic       cmd_err,
   output logic       kbd_ready
);

`ifdef PS2_KBD_RESEND_EN
   localparam bit ResendEn = 1'b1;
`else
   localparam bit ResendEn = 1'b0;
`endif

   localparam int unsigned AckTicks = ms_to_ticks(clkf, ack_timeout_ms);
   localparam int unsigned BatTicks = ms_to_ticks(clkf, bat_timeout_ms);
   localparam int unsigned MaxTicks = (AckTicks > BatTicks) ? AckTicks : BatTicks;
   localparam int unsigned TimerW   = $clog2(MaxTicks + 1);
   localparam int unsigned AttW     = $clog2(max_retries + 1);

   localparam logic [TimerW-1:0] AckLoad = TimerW'(AckTicks);
   localparam logic [TimerW-1:0] BatLoad = TimerW'(BatTicks);

   state_t              state_q, state_d;
   state_t              ret_q, ret_d;
   logic [TimerW-1:0]   timer_q, timer_d, timer_dec;
   logic [AttW-1:0]     att_q, att_d, att_inc;
   logic [7:0]          cmd_q, cmd_d;
   logic                first_q, first_d;
   logic                kbd_ready_q, kbd_ready_d;
   logic                cmd_done_q, cmd_done_d;
   logic                cmd_err_q, cmd_err_d;
   logic                overflow_q, overflow_d;
   logic                rx_good, rx_bad, timeout, retry_ok;
   logic                push, fifo_full, fifo_empty;
   logic [7:0]          tx_byte;

   assign rx_good   = host_rx_valid && !host_error;
   assign rx_bad    = host_rx_valid && host_error;
   assign timeout   = (timer_q == '0);
   assign timer_dec = timeout ? timer_q : timer_q - TimerW'(1);
   assign att_inc   = att_q + AttW'(1);
   assign retry_ok  = (att_inc < AttW'(max_retries));

   // Main sequencer: next state, timers, retry count and event pulses.
   always_comb begin
      state_d     = state_q;
      ret_d       = ret_q;
      timer_d     = timer_q;
      att_d       = att_q;
      cmd_d       = cmd_q;
      first_d     = 1'b0;
      kbd_ready_d = kbd_ready_q;
      cmd_done_d  = 1'b0;
      cmd_err_d   = 1'b0;
      push        = 1'b0;
      case (state_q)
         StRstTx: begin
            first_d = 1'b1;
            state_d = StRstWait;
         end
         // Busy may not have risen yet the cycle after the start strobe.
         StRstWait: begin
            if (!first_q && !host_tx_busy) begin
               timer_d = AckLoad;
               state_d = StRstAck;
            end
         end
         StRstAck: begin
            timer_d = timer_dec;
            if (rx_good && host_rx == RSP_ACK) begin
               timer_d = BatLoad;
               att_d   = '0;
               state_d = StRstBat;
            end else if (rx_good && host_rx == RSP_RESEND || !host_rx_valid && timeout) begin
               att_d = att_inc;
               if (retry_ok) begin
                  state_d = StRstTx;
               end else begin
                  kbd_ready_d = 1'b0;
                  state_d     = StFail;
               end
            end else if (ResendEn && rx_bad) begin
               ret_d   = StRstAck;
               state_d = StRsdTx;
            end
         end
         StRstBat: begin
            timer_d = timer_dec;
            if (rx_good && host_rx == RSP_BAT_OK) begin
               kbd_ready_d = 1'b1;
               state_d     = StIdle;
            end else if (rx_good && host_rx == RSP_BAT_FAIL || !host_rx_valid && timeout) begin
               kbd_ready_d = 1'b0;
               state_d     = StFail;
            end
         end
         StIdle: begin
            push = rx_good;
            if (cmd_valid) begin
               cmd_d   = cmd_data;
               att_d   = '0;
               state_d = StCmdTx;
            end else if (ResendEn && rx_bad) begin
               ret_d   = StIdle;
               state_d = StRsdTx;
            end
         end
         StCmdTx: begin
            first_d = 1'b1;
            state_d = StCmdWait;
         end
         StCmdWait: begin
            if (!first_q && !host_tx_busy) begin
               timer_d = AckLoad;
               state_d = StCmdAck;
            end
         end
         StCmdAck: begin
            timer_d = timer_dec;
            if (rx_good && host_rx == RSP_ACK) begin
               cmd_done_d = 1'b1;
               state_d    = StIdle;
            end else if (rx_good && host_rx == RSP_RESEND || !host_rx_valid && timeout) begin
               att_d = att_inc;
               if (retry_ok) begin
                  state_d = StCmdTx;
               end else begin
                  cmd_err_d = 1'b1;
                  state_d   = StIdle;
               end
            end else if (rx_good) begin
               // Keyboard traffic interleaved with the ACK is still scancode data.
               push = 1'b1;
            end else if (ResendEn && rx_bad) begin
               ret_d   = StCmdAck;
               state_d = StRsdTx;
            end
         end
         StFail: begin
            if (cmd_valid) begin
               cmd_d   = cmd_data;
               att_d   = '0;
               state_d = StCmdTx;
            end
         end
         // Resend request: one shot, no retry accounting, then resume where it left off.
         StRsdTx: begin
            first_d = 1'b1;
            state_d = StRsdWait;
         end
         StRsdWait: begin
            if (!first_q && !host_tx_busy) begin
               timer_d = AckLoad;
               state_d = ret_q;
            end
         end
         default: state_d = StRstTx;
      endcase
   end

   // Sticky overflow: a push that finds the FIFO full with no pop in the same cycle.
   always_comb begin
      overflow_d = overflow_q;
      if (push && fifo_full && !rd_en) overflow_d = 1'b1;
   end

   // Byte presented to the host during the single-cycle TX states.
   always_comb begin
      tx_byte = 8'h00;
      case (state_q)
         StRstTx: tx_byte = CMD_RESET;
         StCmdTx: tx_byte = cmd_q;
         StRsdTx: tx_byte = CMD_RESEND;
         default: tx_byte = 8'h00;
      endcase
   end

   // Controller state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StRstTx;
         ret_q       <= StIdle;
         timer_q     <= '0;
         att_q       <= '0;
         cmd_q       <= '0;
         first_q     <= 1'b0;
         kbd_ready_q <= 1'b0;
         cmd_done_q  <= 1'b0;
         cmd_err_q   <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         timer_q     <= timer_d;
         att_q       <= att_d;
         cmd_q       <= cmd_d;
         first_q     <= first_d;
         kbd_ready_q <= kbd_ready_d;
         cmd_done_q  <= cmd_done_d;
         cmd_err_q   <= cmd_err_d;
         overflow_q  <= overflow_d;
      end
   end

   ps2_rx_fifo #(
      .Depth (fifo_depth),
      .Width (8)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_data_i (host_rx),
      .pop_i       (rd_en),
      .head_o      (rd_data),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // Decoded outputs are held low while reset is asserted.
   assign host_start_tx = !reset && (state_q inside {StRstTx, StCmdTx, StRsdTx});
   assign host_tx       = reset ? 8'h00 : tx_byte;
   assign cmd_ready     = !reset && (state_q == StIdle || state_q == StFail);
   assign empty         = fifo_empty;
   assign overflow      = overflow_q;
   assign cmd_done      = cmd_done_q;
   assign cmd_err       = cmd_err_q;
   assign kbd_ready     = kbd_ready_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl with a byte-level PS2Host model and scaled timeouts
// (1 tick per ms: ACK timeout 20 cycles, BAT timeout 40 cycles).
module tb_ps2_kbd_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] host_rx;
   logic       host_rx_valid;
   logic       host_error;
   logic       host_start_tx;
   logic [7:0] host_tx;
   logic       host_tx_busy;
   logic       cmd_valid;
   logic [7:0] cmd_data;
   logic       cmd_ready;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       empty;
   logic       overflow;
   logic       cmd_done;
   logic       cmd_err;
   logic       kbd_ready;

   int         n_checks = 0;
   int         n_errors = 0;
   int         tx_count = 0;
   int         done_count = 0;
   int         err_count = 0;
   logic [7:0] last_tx = 8'h00;
   int         busy_cnt = 0;
   int         tx0, d0, e0;

   always #5 clk = ~clk;

   ps2_kbd_ctrl #(
      .clkf           (1000),
      .ack_timeout_ms (20),
      .bat_timeout_ms (40),
      .max_retries    (3),
      .fifo_depth     (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .host_rx       (host_rx),
      .host_rx_valid (host_rx_valid),
      .host_error    (host_error),
      .host_start_tx (host_start_tx),
      .host_tx       (host_tx),
      .host_tx_busy  (host_tx_busy),
      .cmd_valid     (cmd_valid),
      .cmd_data      (cmd_data),
      .cmd_ready     (cmd_ready),
      .rd_en         (rd_en),
      .rd_data       (rd_data),
      .empty         (empty),
      .overflow      (overflow),
      .cmd_done      (cmd_done),
      .cmd_err       (cmd_err),
      .kbd_ready     (kbd_ready)
   );

   // Host model: busy for 4 cycles after each start; log every transmitted byte and pulse.
   always @(posedge clk) begin
      if (reset) busy_cnt <= 0;
      else if (host_start_tx) busy_cnt <= 4;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (host_start_tx) begin
         tx_count <= tx_count + 1;
         last_tx  <= host_tx;
      end
      if (cmd_done) done_count <= done_count + 1;
      if (cmd_err)  err_count  <= err_count + 1;
   end
   assign host_tx_busy = (busy_cnt != 0);

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic err);
      host_rx       = b;
      host_error    = err;
      host_rx_valid = 1'b1;
      tick();
      host_rx_valid = 1'b0;
      host_error    = 1'b0;
   endtask

   // Wait until the target number of transmissions is reached and the host is idle again,
   // then one more cycle so the controller is listening for the response.
   task automatic wait_tx_done(input int target);
      int n = 0;
      while (!(tx_count >= target && !host_tx_busy) && n < 100) begin
         tick();
         n++;
      end
      check("tx_done_wait", 32'(n < 100), 32'd1);
      tick();
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
   endtask

   task automatic do_init();
      int t;
      apply_reset();
      t = tx_count;
      wait_tx_done(t + 1);
      send(8'hFA, 1'b0);
      send(8'hAA, 1'b0);
   endtask

   task automatic issue_cmd(input logic [7:0] c);
      cmd_valid = 1'b1;
      cmd_data  = c;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      host_rx       = 8'h00;
      host_rx_valid = 1'b0;
      host_error    = 1'b0;
      cmd_valid     = 1'b0;
      cmd_data      = 8'h00;
      rd_en         = 1'b0;
      tick(3);

      // Reset state
      check("rst_start_tx", 32'(host_start_tx), 32'd0);
      check("rst_host_tx", 32'(host_tx), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_kbd_ready", 32'(kbd_ready), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);

      // Clean init: FA then AA
      tx0 = tx_count;
      reset = 1'b0;
      wait_tx_done(tx0 + 1);
      check("init_tx_byte", 32'(last_tx), 32'hFF);
      send(8'hFA, 1'b0);
      check("init_not_ready_before_bat", 32'(kbd_ready), 32'd0);
      send(8'hAA, 1'b0);
      check("init_kbd_ready", 32'(kbd_ready), 32'd1);
      check("init_tx_count", 32'(tx_count - tx0), 32'd1);
      check("init_empty", 32'(empty), 32'd1);
      check("init_cmd_ready", 32'(cmd_ready), 32'd1);

      // Init with two resends: FE, FE, FA, AA
      apply_reset();
      tx0 = tx_count;
      wait_tx_done(tx0 + 1);
      send(8'hFE, 1'b0);
      wait_tx_done(tx0 + 2);
      send(8'hFE, 1'b0);
      wait_tx_done(tx0 + 3);
      send(8'hFA, 1'b0);
      send(8'hAA, 1'b0);
      check("resend_tx_count", 32'(tx_count - tx0), 32'd3);
      check("resend_last_byte", 32'(last_tx), 32'hFF);
      check("resend_kbd_ready", 32'(kbd_ready), 32'd1);

      // Init with silence: three timeouts -> FAIL
      apply_reset();
      tx0 = tx_count;
      tick(150);
      check("silent_tx_count", 32'(tx_count - tx0), 32'd3);
      check("silent_kbd_ready", 32'(kbd_ready), 32'd0);
      check("silent_cmd_ready", 32'(cmd_ready), 32'd1);
      send(8'hAA, 1'b0);
      tick(2);
      check("fail_ignores_rx_ready", 32'(kbd_ready), 32'd0);
      check("fail_ignores_rx_empty", 32'(empty), 32'd1);

      // Command ED with an interleaved scancode before the ACK
      do_init();
      tx0 = tx_count;
      d0  = done_count;
      issue_cmd(8'hED);
      wait_tx_done(tx0 + 1);
      check("cmd_tx_byte", 32'(last_tx), 32'hED);
      send(8'h1C, 1'b0);
      send(8'hFA, 1'b0);
      tick(5);
      check("cmd_done_once", 32'(done_count - d0), 32'd1);
      check("cmd_scancode_pushed", 32'(empty), 32'd0);
      check("cmd_scancode_value", 32'(rd_data), 32'h1C);
      check("cmd_back_idle", 32'(cmd_ready), 32'd1);
      pop();
      check("cmd_pop_empty", 32'(empty), 32'd1);

      // Command with no response: retries exhausted -> cmd_err
      tx0 = tx_count;
      e0  = err_count;
      d0  = done_count;
      issue_cmd(8'hF4);
      tick(150);
      check("cmderr_tx_count", 32'(tx_count - tx0), 32'd3);
      check("cmderr_last_byte", 32'(last_tx), 32'hF4);
      check("cmderr_pulse", 32'(err_count - e0), 32'd1);
      check("cmderr_no_done", 32'(done_count - d0), 32'd0);
      check("cmderr_idle", 32'(cmd_ready), 32'd1);
      check("cmderr_kbd_ready", 32'(kbd_ready), 32'd1);

      // Nine scancodes with no pops: overflow, first eight retained
      for (int i = 1; i <= 9; i++) send(8'(i), 1'b0);
      check("ovf_set", 32'(overflow), 32'd1);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("ovf_order_%0d", i), 32'(rd_data), 32'(i));
         pop();
      end
      check("ovf_drained", 32'(empty), 32'd1);
      check("ovf_sticky", 32'(overflow), 32'd1);

      // Full FIFO with simultaneous push and pop: no overflow
      do_init();
      check("sim_ovf_cleared", 32'(overflow), 32'd0);
      for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0);
      check("sim_full_no_ovf", 32'(overflow), 32'd0);
      rd_en = 1'b1;
      send(8'h18, 1'b0);
      rd_en = 1'b0;
      check("sim_push_pop_no_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("sim_order_%0d", i), 32'(rd_data), 32'h11 + 32'(i));
         pop();
      end
      check("sim_drained", 32'(empty), 32'd1);

      // Bad-parity byte in IDLE
      tx0 = tx_count;
      send(8'h55, 1'b1);
      tick(30);
      check("parity_fifo_unchanged", 32'(empty), 32'd1);
      check("parity_no_overflow", 32'(overflow), 32'd0);
`ifdef PS2_KBD_RESEND_EN
      check("parity_resend_count", 32'(tx_count - tx0), 32'd1);
      check("parity_resend_byte", 32'(last_tx), 32'hFE);
`else
      check("parity_no_tx", 32'(tx_count - tx0), 32'd0);
`endif
      check("parity_idle", 32'(cmd_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
